// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: req/ack imem port, PC-tagged decode FIFO
//
// Purpose:
//   Samples the word-index PC, issues one outstanding read to instruction
//   memory at byte address pc<<2, buffers returned words with their PC in a
//   DEPTH-entry FIFO and presents the head to decode over valid/ready.
//   pc_advance pulses in the cycle a fetched word is accepted, so the PC
//   stage increments at the same edge the word is captured.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   pc           current PC (word index)
//   flush        redirect: drop buffered and in-flight instructions
//   pc_advance   one-cycle pulse, PC increments at next edge
//   imem_req     read request, held until imem_ack
//   imem_addr    byte address {pc_lat[29:0],2'b00}
//   imem_ack     single-cycle read completion
//   imem_rdata   instruction word, valid with imem_ack
//   inst_valid   decode head valid
//   inst_ready   decode accepts head
//   inst         head instruction (0 when not valid)
//   inst_pc      head PC (0 when not valid)
//
// Options:
//   IFETCH_BYPASS_EN  when defined, an accepted word arriving at an empty
//                     FIFO is shown to decode in the ack cycle itself.

module instr_fetch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        pc_advance,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_lat_q, pc_lat_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   fifo_inst_q [DEPTH];
   logic [31:0]   fifo_pc_q   [DEPTH];

   logic          fifo_valid;
   logic          accept;
   logic          bypass;
   logic          push;
   logic          pop;

   assign fifo_valid = (count_q != '0);

   // Only a WAIT-state ack that is not being flushed delivers a word;
   // acks seen in DROP belong to a request that was redirected away.
   assign accept = (state_q == WAIT) && imem_ack && !flush;

`ifdef IFETCH_BYPASS_EN
   assign bypass = accept && !fifo_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word taken by decode in the same cycle never enters the FIFO.
   assign push = accept && !(bypass && inst_ready);
   assign pop  = fifo_valid && inst_ready;

   assign imem_req   = (state_q != IDLE);
   assign imem_addr  = {pc_lat_q[29:0], 2'b00};
   assign pc_advance = accept;

   always_comb begin
      state_d  = state_q;
      pc_lat_d = pc_lat_q;
      case (state_q)
         IDLE: begin
            // Issue only with a free slot, so the returning word always fits.
            if (!flush && (count_q < FULL)) begin
               pc_lat_d = pc;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               state_d = IDLE;
            end else if (flush) begin
               state_d = DROP;
            end
         end
         DROP: begin
            // The request cannot be withdrawn; wait it out and discard.
            if (imem_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      inst_valid = fifo_valid;
      inst       = '0;
      inst_pc    = '0;
      if (fifo_valid) begin
         inst    = fifo_inst_q[rd_ptr_q];
         inst_pc = fifo_pc_q[rd_ptr_q];
      end else if (bypass) begin
         inst_valid = 1'b1;
         inst       = imem_rdata;
         inst_pc    = pc_lat_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         pc_lat_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_lat_q <= pc_lat_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         fifo_inst_q[wr_ptr_q] <= imem_rdata;
         fifo_pc_q[wr_ptr_q]   <= pc_lat_q;
      end
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter in the RISC-V unicycle core. It reads the current word-index PC and issues a req/ack read to instruction memory at byte address `pc<<2`. Returned instructions are buffered with their PC in a small FIFO and presented to decode over a valid/ready handshake. A one-cycle `pc_advance` pulse tells the PC to increment only once an instruction has actually been captured.

## Interface
- `DEPTH`, 2: FIFO entries; power of 2, minimum 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `pc`  in  32  current PC, word index, from PC stage.
- `flush`  in  1  redirect: discard buffered and in-flight instructions.
- `pc_advance`  out  1  one-cycle pulse: PC must increment at next edge.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  32  byte address, `{pc_lat[29:0],2'b00}`.
- `imem_ack`  in  1  single-cycle completion; valid only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst`  out  32  head instruction; 0 when `inst_valid`=0.
- `inst_pc`  out  32  head PC (word index); 0 when `inst_valid`=0.

## Operation
- FSM states: IDLE, WAIT, DROP. `imem_req` = (state != IDLE), decoded from registered state.
- IDLE: if `flush`=0 and count < DEPTH, latch `pc` into `pc_lat` and go to WAIT. Otherwise stay in IDLE.
- WAIT: `imem_req` and `imem_addr` are held stable until ack.
  - `imem_ack`=1 and `flush`=0: push {`pc_lat`, `imem_rdata`}, assert `pc_advance`, go to IDLE.
  - `imem_ack`=1 and `flush`=1: discard the data, no `pc_advance`, go to IDLE.
  - `imem_ack`=0 and `flush`=1: go to DROP.
- DROP: `imem_req` stays high because a request cannot be withdrawn. On `imem_ack`, discard the data and go to IDLE. `flush` in DROP has no further effect.
- FIFO:
  - Pop when `inst_valid && inst_ready`.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
  - Overflow is impossible: at most one request is outstanding, and it is issued only when count < DEPTH.
  - Pop when empty is ignored.
- `flush` clears the FIFO (count=0, pointers=0) at the next edge and overrides any same-cycle push or pop.
- Reset (async, level):
  - state=IDLE, FIFO empty.
  - `imem_req`=0, `pc_advance`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `imem_addr`=0.
  - A request in flight when reset asserts is abandoned; memory must tolerate this.

## Timing
- IDLE decision at edge t → `imem_req`=1 from t.
- Zero-wait memory (ack in the first req cycle): instruction pushed at edge t+1, `inst_valid`=1 in cycle t+1. Fetch-to-decode latency is 1 cycle after the ack cycle.
- `pc_advance` is asserted in the ack cycle; PC updates at the same edge the push happens. The next IDLE cycle therefore samples the new `pc`.
- Sustained throughput with zero-wait memory: 1 instruction per 2 cycles.
- N wait cycles (ack N cycles after req rises) add N cycles of latency.
- `pc_advance` is asserted only in WAIT with `imem_ack`=1 and `flush`=0; never in DROP.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When the FIFO is empty and an accepted ack occurs, the FIFO is bypassed: `inst_valid`=1 in the ack cycle, `inst`=`imem_rdata`, `inst_pc`=`pc_lat`.
  - If `inst_ready`=1 in that cycle, nothing is pushed; otherwise the word is pushed as normal.
  - Latency becomes 0 cycles after ack.
- `IFETCH_BYPASS_EN` undefined: all instructions pass through the FIFO, with the 1-cycle latency above.

## Test plan
- **Reset:** reset=0 mid-WAIT with `pc`=5 → `imem_req`, `inst_valid` and `pc_advance` all drop to 0 immediately. After release, the first request has `imem_addr`=0x14.
- **Zero-wait streaming:** `inst_ready`=1, ack in the first req cycle, PC model starting at 0 → `inst_pc` sequence 0,1,2,3 with `imem_addr` 0x0,0x4,0x8,0xC. One `pc_advance` per instruction; one instruction every 2 cycles.
- **Backpressure:** `inst_ready`=0, DEPTH=2 → exactly 2 instructions buffered, then `imem_req` stays 0. Raising `inst_ready` drains 0,1 in order and fetching resumes at pc=2.
- **Flush during WAIT:** ack delayed 3 cycles, `flush` pulsed in the first WAIT cycle → state DROP. The late ack is discarded, no `pc_advance`, and the FIFO is empty. The next request uses the redirected `pc`=0x40 (`imem_addr`=0x100).
- **Flush coincident with ack and pop:** FIFO holds 1 entry, same cycle has `flush`, `imem_ack`, `inst_ready` → FIFO empty afterwards, `pc_advance`=0, state IDLE.
- **Bypass (`IFETCH_BYPASS_EN`):** FIFO empty, ack with `imem_rdata`=0x00500093, `inst_ready`=1 → `inst_valid`=1 in the ack cycle with that data, and FIFO count stays 0.
